// File: rtl/column_scroll_ctrl.sv
// Column streamer for a side-scroller: preloads the visible block columns from the
// level ROM, then fetches one new column per accepted frame once Mario passes SCROLL_X.
module column_scroll_ctrl #(
    parameter int         NUM_COLS  = 10,
    parameter int         LEVEL_LEN = 212,
    parameter int         ROM_LAT   = 2,
    parameter logic [9:0] SCROLL_X  = 10'd320
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic [9:0]  mario_x,
    input  logic        mario_right,
    output logic        rom_rd,
    output logic [7:0]  rom_addr,
    input  logic [29:0] rom_data,
    output logic [29:0] new_block_id,
    output logic        shift,
    output logic        mario_x_adjust,
    output logic        preload_busy,
    output logic [7:0]  col_index,
    output logic        level_end
);

    localparam int             CW         = $clog2(ROM_LAT + 1) + 1;
    localparam logic [CW-1:0]  WAIT_LAST  = CW'(ROM_LAT);
    localparam logic [7:0]     LAST_COL   = 8'(LEVEL_LEN);
    // A level shorter than the screen stops the preload at its own length.
    localparam logic [7:0]     PRE_COLS   = 8'((NUM_COLS < LEVEL_LEN) ? NUM_COLS : LEVEL_LEN);

    typedef enum logic [2:0] {
        PRE_REQ, PRE_WAIT, PRE_SHIFT, IDLE, FETCH_REQ, FETCH_WAIT, SCROLL, END
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   wait_cnt_reg;
    logic [7:0]      col_inc;
    logic            scroll_req;

    assign col_inc    = col_index + 8'd1;
    assign scroll_req = frame_tick && mario_right && (mario_x >= SCROLL_X) && (col_index < LAST_COL);
    assign rom_addr   = col_index;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg      <= PRE_REQ;
            wait_cnt_reg   <= '0;
            col_index      <= 8'd0;
            new_block_id   <= 30'd0;
            rom_rd         <= 1'b0;
            shift          <= 1'b0;
            mario_x_adjust <= 1'b0;
            level_end      <= 1'b0;
            preload_busy   <= 1'b1;
        end else begin
            rom_rd         <= 1'b0;
            shift          <= 1'b0;
            mario_x_adjust <= 1'b0;
            case (state_reg)
                PRE_REQ: begin
                    if (col_index >= LAST_COL) begin
                        state_reg    <= END;
                        preload_busy <= 1'b0;
                        level_end    <= 1'b1;
                    end else begin
                        rom_rd       <= 1'b1;
                        wait_cnt_reg <= '0;
                        state_reg    <= PRE_WAIT;
                    end
                end
                PRE_WAIT, FETCH_WAIT: begin
                    // Count is 0 during the rom_rd cycle, so WAIT_LAST lands on valid data.
                    if (wait_cnt_reg == WAIT_LAST) begin
                        new_block_id <= rom_data;
                        shift        <= 1'b1;
                        if (state_reg == FETCH_WAIT) begin
                            mario_x_adjust <= 1'b1;
                            state_reg      <= SCROLL;
                        end else begin
                            state_reg      <= PRE_SHIFT;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                PRE_SHIFT: begin
                    col_index <= col_inc;
                    if (col_inc >= LAST_COL) begin
                        state_reg    <= END;
                        preload_busy <= 1'b0;
                        level_end    <= 1'b1;
                    end else if (col_inc >= PRE_COLS) begin
                        state_reg    <= IDLE;
                        preload_busy <= 1'b0;
                    end else begin
                        state_reg    <= PRE_REQ;
                    end
                end
                IDLE: begin
                    if (scroll_req) state_reg <= FETCH_REQ;
                end
                FETCH_REQ: begin
                    rom_rd       <= 1'b1;
                    wait_cnt_reg <= '0;
                    state_reg    <= FETCH_WAIT;
                end
                SCROLL: begin
                    col_index <= col_inc;
                    if (col_inc >= LAST_COL) begin
                        state_reg <= END;
                        level_end <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                END:     state_reg <= END;
                default: state_reg <= PRE_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_column_scroll_ctrl.sv
// Bench for column_scroll_ctrl: two instances (full level and a 12-column level) share
// stimulus; a per-instance reference model tracks columns, fetches and ROM latency.
module tb_column_scroll_ctrl;

    localparam int ROM_LAT  = 2;
    localparam int NUM_COLS = 10;
    localparam int LEN_A    = 212;
    localparam int LEN_B    = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       frame_tick = 1'b0;
    logic [9:0] mario_x = 10'd0;
    logic       mario_right = 1'b0;

    logic        rd_a, sh_a, adj_a, busy_a, lend_a;
    logic [7:0]  addr_a, col_a;
    logic [29:0] data_a, nbid_a;
    logic        rd_b, sh_b, adj_b, busy_b, lend_b;
    logic [7:0]  addr_b, col_b;
    logic [29:0] data_b, nbid_b;

    always #5 clk = ~clk;

    column_scroll_ctrl #(.NUM_COLS(NUM_COLS), .LEVEL_LEN(LEN_A), .ROM_LAT(ROM_LAT), .SCROLL_X(10'd320)) dut_a (
        .Clk(clk), .Reset(rst_n), .frame_tick(frame_tick), .mario_x(mario_x), .mario_right(mario_right),
        .rom_rd(rd_a), .rom_addr(addr_a), .rom_data(data_a), .new_block_id(nbid_a), .shift(sh_a),
        .mario_x_adjust(adj_a), .preload_busy(busy_a), .col_index(col_a), .level_end(lend_a));

    column_scroll_ctrl #(.NUM_COLS(NUM_COLS), .LEVEL_LEN(LEN_B), .ROM_LAT(ROM_LAT), .SCROLL_X(10'd320)) dut_b (
        .Clk(clk), .Reset(rst_n), .frame_tick(frame_tick), .mario_x(mario_x), .mario_right(mario_right),
        .rom_rd(rd_b), .rom_addr(addr_b), .rom_data(data_b), .new_block_id(nbid_b), .shift(sh_b),
        .mario_x_adjust(adj_b), .preload_busy(busy_b), .col_index(col_b), .level_end(lend_b));

    // Level ROM: data appears ROM_LAT cycles after the read strobe, junk otherwise.
    logic [29:0] rom_mem [256];
    logic [29:0] pipe_a [ROM_LAT];
    logic [29:0] pipe_b [ROM_LAT];
    assign data_a = pipe_a[ROM_LAT-1];
    assign data_b = pipe_b[ROM_LAT-1];

    always @(posedge clk) begin
        pipe_a[0] <= rd_a ? rom_mem[addr_a] : 30'($urandom);
        pipe_b[0] <= rd_b ? rom_mem[addr_b] : 30'($urandom);
        for (int k = 1; k < ROM_LAT; k++) begin
            pipe_a[k] <= pipe_a[k-1];
            pipe_b[k] <= pipe_b[k-1];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int          len_of [2] = '{LEN_A, LEN_B};
    int          exp_col [2];
    bit          fetching [2];
    bit          pend [2];
    int          pend_addr [2];
    int          pend_cyc [2];
    logic [29:0] exp_nbid [2];
    int          rd_cnt [2];
    int          shift_cnt [2];
    int          scroll_cnt [2];
    int          accepted [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon(input int d, input logic rd, input logic [7:0] addr, input logic [29:0] nbid,
                       input logic sh, input logic adj, input logic busy, input logic [7:0] col,
                       input logic lend);
        int target;
        bit pre;
        string p;
        p = (d == 0) ? "a" : "b";
        target = (NUM_COLS < len_of[d]) ? NUM_COLS : len_of[d];
        if (!rst_n) begin
            chk({p, ":rst_rd"}, 32'(rd), 0);
            chk({p, ":rst_shift"}, 32'(sh), 0);
            chk({p, ":rst_adj"}, 32'(adj), 0);
            chk({p, ":rst_busy"}, 32'(busy), 1);
            chk({p, ":rst_col"}, 32'(col), 0);
            chk({p, ":rst_nbid"}, 32'(nbid), 0);
            chk({p, ":rst_lend"}, 32'(lend), 0);
            exp_col[d] = 0; fetching[d] = 0; pend[d] = 0; exp_nbid[d] = '0;
            rd_cnt[d] = 0; shift_cnt[d] = 0; scroll_cnt[d] = 0; accepted[d] = 0;
            return;
        end
        pre = exp_col[d] < target;
        // One scroll per accepted tick; ticks during preload or an open fetch are dropped.
        if (frame_tick && mario_right && (mario_x >= 10'd320) && !pre && !fetching[d]
            && exp_col[d] < len_of[d]) begin
            fetching[d] = 1;
            accepted[d]++;
        end
        chk({p, ":addr_eq_col"}, 32'(addr), 32'(col));
        chk({p, ":col"}, 32'(col), 32'(exp_col[d]));
        chk({p, ":preload_busy"}, 32'(busy), 32'(pre));
        chk({p, ":level_end"}, 32'(lend), 32'(exp_col[d] >= len_of[d]));
        chk({p, ":rd_and_shift"}, 32'(rd && sh), 0);
        chk({p, ":adjust"}, 32'(adj), 32'(sh && !pre));
        if (rd) begin
            chk({p, ":rd_allowed"}, 32'(pre || fetching[d]), 1);
            chk({p, ":rd_single"}, 32'(pend[d]), 0);
            pend[d] = 1; pend_addr[d] = int'(addr); pend_cyc[d] = cyc; rd_cnt[d]++;
        end
        if (sh) begin
            chk({p, ":shift_after_rd"}, 32'(pend[d]), 1);
            chk({p, ":shift_latency"}, 32'(cyc - pend_cyc[d]), 32'(ROM_LAT + 1));
            chk({p, ":nbid_capture"}, 32'(nbid), 32'(rom_mem[pend_addr[d]]));
            exp_nbid[d] = rom_mem[pend_addr[d]];
            pend[d] = 0;
            exp_col[d]++;
            shift_cnt[d]++;
            if (!pre) begin
                scroll_cnt[d]++;
                fetching[d] = 0;
            end
        end else begin
            chk({p, ":nbid_hold"}, 32'(nbid), 32'(exp_nbid[d]));
        end
    endtask

    always @(negedge clk) begin
        mon(0, rd_a, addr_a, nbid_a, sh_a, adj_a, busy_a, col_a, lend_a);
        mon(1, rd_b, addr_b, nbid_b, sh_b, adj_b, busy_b, col_b, lend_b);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_once(input logic [9:0] mx, input logic right);
        step();
        mario_x = mx; mario_right = right; frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && (fetching[0] || fetching[1]); i++) step();
        chk("drain_a", 32'(fetching[0]), 0);
        chk("drain_b", 32'(fetching[1]), 0);
    endtask

    task automatic wait_preload();
        for (int i = 0; i < 300 && !(shift_cnt[0] == NUM_COLS && !busy_a); i++) step();
    endtask

    initial begin
        int sc0, acc0;
        bit found;
        for (int a = 0; a < 256; a++)
            rom_mem[a] = (a < NUM_COLS) ? 30'((a + 1) * 3) : 30'($urandom);

        #2 rst_n = 1'b0;
        repeat (3) step();
        chk("reset_busy", 32'(busy_a), 1);
        chk("reset_rd", 32'(rd_a), 0);
        rst_n = 1'b1;
        step();
        chk("first_rd_a", 32'(rd_a), 1);
        chk("first_addr_a", 32'(addr_a), 0);
        chk("first_rd_b", 32'(rd_b), 1);

        // Preload: ten columns carrying 3, 6, ... 30.
        wait_preload();
        chk("preload_shifts", 32'(shift_cnt[0]), NUM_COLS);
        chk("preload_done", 32'(busy_a), 0);
        chk("preload_col", 32'(col_a), NUM_COLS);
        chk("preload_last_nbid", 32'(nbid_a), 30);
        step();

        // Single scroll at exactly the threshold.
        tick_once(10'd320, 1'b1);
        drain();
        chk("scroll1_count", 32'(scroll_cnt[0]), 1);
        chk("scroll1_col", 32'(col_a), 11);
        chk("scroll1_col_b", 32'(col_b), 11);
        chk("scroll1_rd", 32'(rd_cnt[0]), 11);

        // Just below threshold, and moving left: nothing happens.
        tick_once(10'd319, 1'b1);
        tick_once(10'd320, 1'b0);
        repeat (8) step();
        chk("noscroll_rd", 32'(rd_cnt[0]), 11);
        chk("noscroll_shift", 32'(shift_cnt[0]), 11);

        // Tick every cycle: only ticks that find the controller idle are taken.
        sc0 = scroll_cnt[0]; acc0 = accepted[0];
        mario_x = 10'd400; mario_right = 1'b1; frame_tick = 1'b1;
        repeat (30) step();
        frame_tick = 1'b0;
        drain();
        chk("burst_match", 32'(scroll_cnt[0] - sc0), 32'(accepted[0] - acc0));
        chk("burst_dropped", 32'((accepted[0] - acc0) > 1 && (accepted[0] - acc0) < 30), 1);

        // Randomised ticks around the threshold.
        for (int i = 0; i < 80; i++) begin
            mario_x     = 10'($urandom_range(300, 340));
            mario_right = ($urandom_range(0, 3) != 0);
            frame_tick  = $urandom_range(0, 1) != 0;
            step();
        end
        frame_tick = 1'b0;
        drain();
        chk("random_match", 32'(scroll_cnt[0]), 32'(accepted[0]));

        // Short level stops after two scrolls.
        chk("short_scrolls", 32'(scroll_cnt[1]), 2);
        chk("short_level_end", 32'(lend_b), 1);
        chk("short_col", 32'(col_b), LEN_B);
        chk("short_rd", 32'(rd_cnt[1]), LEN_B);
        chk("long_no_end", 32'(lend_a), 0);

        // Reset in the middle of the fifth preload fetch.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (rd_a && addr_a == 8'd4) found = 1;
        end
        chk("fifth_rd_seen", 32'(found), 1);
        step();
        rst_n = 1'b0;
        #1;
        chk("async_rd", 32'(rd_a), 0);
        chk("async_shift", 32'(sh_a), 0);
        chk("async_busy", 32'(busy_a), 1);
        chk("async_col", 32'(col_a), 0);
        chk("async_nbid", 32'(nbid_a), 0);
        chk("async_lend_b", 32'(lend_b), 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("restart_rd", 32'(rd_a), 1);
        chk("restart_addr", 32'(addr_a), 0);
        wait_preload();
        repeat (20) step();
        chk("restart_shifts", 32'(shift_cnt[0]), NUM_COLS);
        chk("restart_col", 32'(col_a), NUM_COLS);
        chk("restart_busy", 32'(busy_a), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
